// File: rtl/shift_sequencer16_if.sv
// Request/response bundle for shift_sequencer16.
//   Start    : request strobe, sampled only when the engine is not busy
//   Op       : 0 LSL, 1 LSR, 2 ASR, 3 ROR (sampled with Start)
//   Amount   : shift count 0..BITS-1 (sampled with Start)
//   A        : operand (sampled with Start)
//   Busy     : high while shifting
//   Done     : one-cycle pulse, Result/CarryOut final while high
//   Result   : working/result register
//   CarryOut : last bit shifted or rotated out (0 for Amount=0)
// master = requester side, slave = shift engine side.
interface shift_sequencer16_if #(
  parameter int BITS = 16,
  parameter int CNTW = 4
);
  logic            Start;
  logic [1:0]      Op;
  logic [CNTW-1:0] Amount;
  logic [BITS-1:0] A;
  logic            Busy;
  logic            Done;
  logic [BITS-1:0] Result;
  logic            CarryOut;

  modport master (
    output Start, Op, Amount, A,
    input  Busy, Done, Result, CarryOut
  );

  modport slave (
    input  Start, Op, Amount, A,
    output Busy, Done, Result, CarryOut
  );
endinterface

// File: rtl/shift_sequencer16.sv
// Multi-cycle shift engine: performs LSL/LSR/ASR/ROR by applying one
// single-bit step per clock, then pulses Done for one cycle.
// Ports:
//   CLK : system clock, rising-edge active
//   RST : synchronous active-high reset (priority over Start)
//   bus : shift_sequencer16_if.slave (Start/Op/Amount/A in,
//         Busy/Done/Result/CarryOut out)
// All outputs come from registers or from decoding the state register.
module shift_sequencer16 #(
  parameter int BITS = 16,
  parameter int CNTW = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  shift_sequencer16_if.slave    bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_LSL = 2'd0;
  localparam logic [1:0] OP_LSR = 2'd1;
  localparam logic [1:0] OP_ASR = 2'd2;
  localparam logic [1:0] OP_ROR = 2'd3;

  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  logic [1:0]      state_r;
  logic [1:0]      op_r;
  logic [CNTW-1:0] count_r;
  logic [BITS-1:0] result_r;
  logic            carry_r;

  logic [BITS-1:0] step_result_s;
  logic            step_carry_s;
  logic            can_accept_s;

  // New requests are only looked at when no shift is in flight.
  assign can_accept_s = (state_r == ST_IDLE) || (state_r == ST_DONE);

  // One single-bit step of the latched operation applied to the working register.
  always_comb begin
    step_result_s = result_r;
    step_carry_s  = 1'b0;
    case (op_r)
      OP_LSL: begin
        step_carry_s  = result_r[BITS-1];
        step_result_s = {result_r[BITS-2:0], 1'b0};
      end
      OP_LSR: begin
        step_carry_s  = result_r[0];
        step_result_s = {1'b0, result_r[BITS-1:1]};
      end
      OP_ASR: begin
        step_carry_s  = result_r[0];
        step_result_s = {result_r[BITS-1], result_r[BITS-1:1]};
      end
      OP_ROR: begin
        step_carry_s  = result_r[0];
        step_result_s = {result_r[0], result_r[BITS-1:1]};
      end
      default: begin
        step_carry_s  = 1'b0;
        step_result_s = result_r;
      end
    endcase
  end

  // Sequencer state, working register, carry, count and latched op.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      op_r     <= OP_LSL;
      count_r  <= CNT_ZERO;
      result_r <= {BITS{1'b0}};
      carry_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (can_accept_s && bus.Start) begin
            result_r <= bus.A;
            carry_r  <= 1'b0;
            op_r     <= bus.Op;
            count_r  <= bus.Amount;
            // A zero amount skips SHIFT so count can never wrap.
            state_r  <= (bus.Amount == CNT_ZERO) ? ST_DONE : ST_SHIFT;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          result_r <= step_result_s;
          carry_r  <= step_carry_s;
          count_r  <= count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Busy     = (state_r == ST_SHIFT);
  assign bus.Done     = (state_r == ST_DONE);
  assign bus.Result   = result_r;
  assign bus.CarryOut = carry_r;

endmodule

// File: tb/tb_shift_sequencer16.sv
// Self-checking bench for shift_sequencer16: directed scenarios followed by
// randomized requests, compared against an arithmetic reference model.
module tb_shift_sequencer16;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  shift_sequencer16_if #(.BITS(16), .CNTW(4)) bus ();

  shift_sequencer16 #(.BITS(16), .CNTW(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: final {carry, result} computed directly from the shift rules.
  function automatic logic [16:0] ref_shift(input logic [1:0] op,
                                            input int n,
                                            input logic [15:0] a);
    int unsigned w;
    int          s;
    int unsigned res;
    int unsigned cy;
    w  = a;
    s  = $signed(a);
    res = w;
    cy  = 0;
    case (op)
      2'd0: begin
        res = (w << n) & 32'hFFFF;
        cy  = (n == 0) ? 0 : ((w >> (16 - n)) & 1);
      end
      2'd1: begin
        res = w >> n;
        cy  = (n == 0) ? 0 : ((w >> (n - 1)) & 1);
      end
      2'd2: begin
        res = (s >>> n) & 32'hFFFF;
        cy  = (n == 0) ? 0 : ((w >> (n - 1)) & 1);
      end
      default: begin
        res = ((w >> n) | (w << (16 - n))) & 32'hFFFF;
        cy  = (n == 0) ? 0 : ((w >> (n - 1)) & 1);
      end
    endcase
    return {cy[0], res[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it through Busy, Done and the hold cycle.
  task automatic run_op(input logic [1:0] op, input int n, input logic [15:0] a);
    logic [16:0] exp;
    exp = ref_shift(op, n, a);
    bus.Start  = 1'b1;
    bus.Op     = op;
    bus.Amount = n[3:0];
    bus.A      = a;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("busy_during_shift", {31'd0, bus.Busy}, 32'd1);
      chk("no_done_during_shift", {31'd0, bus.Done}, 32'd0);
      tick();
    end
    chk("done_pulse", {31'd0, bus.Done}, 32'd1);
    chk("busy_in_done", {31'd0, bus.Busy}, 32'd0);
    chk("result", {16'd0, bus.Result}, {16'd0, exp[15:0]});
    chk("carry", {31'd0, bus.CarryOut}, {31'd0, exp[16]});
    tick();
    chk("done_one_cycle", {31'd0, bus.Done}, 32'd0);
    chk("result_hold", {16'd0, bus.Result}, {16'd0, exp[15:0]});
  endtask

  initial begin
    int done_seen;
    vectors     = 0;
    miscompares = 0;
    rst        = 1'b1;
    bus.Start  = 1'b0;
    bus.Op     = 2'd0;
    bus.Amount = 4'd0;
    bus.A      = 16'h0000;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
    chk("reset_done", {31'd0, bus.Done}, 32'd0);
    chk("reset_result", {16'd0, bus.Result}, 32'd0);
    chk("reset_carry", {31'd0, bus.CarryOut}, 32'd0);

    // Directed cases from the plan.
    run_op(2'd0, 4,  16'h0001);
    run_op(2'd2, 3,  16'h8001);
    run_op(2'd3, 4,  16'h1234);
    run_op(2'd1, 15, 16'hFFFF);
    for (int op = 0; op < 4; op++) begin
      run_op(op[1:0], 0, 16'hBEEF);
    end

    // Long LSL with an ignored Start mid-shift, then aborted by reset.
    bus.Start = 1'b1; bus.Op = 2'd0; bus.Amount = 4'd10; bus.A = 16'h0003;
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
    bus.Start = 1'b1; bus.A = 16'hFFFF; bus.Op = 2'd3; bus.Amount = 4'd0;
    tick();
    bus.Start = 1'b0;
    chk("ignored_start_busy", {31'd0, bus.Busy}, 32'd1);
    chk("ignored_start_result", {16'd0, bus.Result}, 32'h0018);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
    chk("abort_done", {31'd0, bus.Done}, 32'd0);
    chk("abort_result", {16'd0, bus.Result}, 32'd0);
    chk("abort_carry", {31'd0, bus.CarryOut}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.Done === 1'b1) done_seen++;
      tick();
    end
    chk("abort_no_done", done_seen, 32'd0);
    run_op(2'd0, 5, 16'h0003);

    // Back-to-back: second request accepted on the DONE-exit edge.
    bus.Start = 1'b1; bus.Op = 2'd0; bus.Amount = 4'd1; bus.A = 16'h0001;
    tick();
    chk("b2b_busy1", {31'd0, bus.Busy}, 32'd1);
    tick();
    chk("b2b_done1", {31'd0, bus.Done}, 32'd1);
    chk("b2b_result1", {16'd0, bus.Result}, 32'h0002);
    chk("b2b_carry1", {31'd0, bus.CarryOut}, 32'd0);
    bus.Op = 2'd3; bus.Amount = 4'd1; bus.A = 16'h0001;
    tick();
    bus.Start = 1'b0;
    chk("b2b_busy2", {31'd0, bus.Busy}, 32'd1);
    chk("b2b_done_gap", {31'd0, bus.Done}, 32'd0);
    tick();
    chk("b2b_done2", {31'd0, bus.Done}, 32'd1);
    chk("b2b_result2", {16'd0, bus.Result}, 32'h8000);
    chk("b2b_carry2", {31'd0, bus.CarryOut}, 32'd1);
    tick();

    // Randomized requests.
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  rop;
      int          rn;
      logic [15:0] ra;
      rop = 2'($urandom_range(3, 0));
      rn  = int'($urandom_range(15, 0));
      ra  = 16'($urandom);
      run_op(rop, rn, ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_sequencer16.md
# shift_sequencer16

Multi-cycle shift engine for the RISC datapath. It accepts an operand, a shift operation and a shift amount. It performs the shift one bit position per clock and returns the result with a one-cycle `Done` pulse. It controls shifting by issuing single-bit shift steps through amounts of 0 to BITS-1, which the combinational single-step shifter cannot do.

## Interface
- `BITS`, 16, operand/result width.
- `CNTW`, 4, shift-amount width; BITS must equal 2^CNTW.

- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `Start`  in  1  request. Sampled only when the block is not busy (state IDLE or DONE).
- `Op`  in  2  operation, sampled with `Start`:
  - 0 = LSL (shift left, fill 0)
  - 1 = LSR (shift right, fill 0)
  - 2 = ASR (shift right, fill with MSB)
  - 3 = ROR (rotate right)
- `Amount`  in  CNTW  shift count 0..BITS-1, sampled with `Start`.
- `A`  in  BITS  operand, sampled with `Start`.
- `Busy`  out  1  high while shifting (state SHIFT).
- `Done`  out  1  one-cycle pulse; `Result`/`CarryOut` are final while it is high.
- `Result`  out  BITS  working register. It holds the final value from `Done` until the next accepted `Start`.
- `CarryOut`  out  1  last bit shifted or rotated out. It is 0 when Amount=0.

## Operation
- States: IDLE, SHIFT, DONE. A registered shift register, a count register (CNTW bits) and an op register.
- Accept condition: `Start`=1 while in IDLE or DONE. On accept:
  - `Result`<=A, `CarryOut`<=0, op<=Op, count<=Amount.
  - If Amount=0, next state is DONE; otherwise SHIFT.
- SHIFT, per edge: apply one single-bit step, count<=count-1.
  - LSL: `CarryOut`<=R[BITS-1], R<={R[BITS-2:0],0}.
  - LSR: `CarryOut`<=R[0], R<={0,R[BITS-1:1]}.
  - ASR: `CarryOut`<=R[0], R<={R[BITS-1],R[BITS-1:1]}.
  - ROR: `CarryOut`<=R[0], R<={R[0],R[BITS-1:1]}.
  - When count=1 at the edge, next state is DONE.
- DONE: `Done`=1 for exactly one cycle. Next state is IDLE, or accepts a new request if `Start`=1 (back-to-back).
- `Start` while in SHIFT is ignored. It is neither queued nor does it disturb the operation.
- Count never wraps: SHIFT is entered only with count≥1.
- `Busy` and `Done` are decoded from state and are never high together.
- Reset (any state, including mid-SHIFT): state<=IDLE, `Result`<=0, `CarryOut`<=0, count<=0. `Busy`=0 and `Done`=0 from the cycle after the reset edge. An aborted operation never produces `Done`.
- `RST` has priority over `Start` on the same edge.

## Timing
- Accept edge = edge k.
- Amount N≥1:
  - `Busy` high in the cycles following edges k..k+N-1.
  - `Done` high in the cycle following edge k+N.
  - Latency from `Start` sample to `Done` is N cycles.
- Amount 0: `Done` high in the cycle following edge k; `Busy` never rises.
- Minimum issue interval is N+1 cycles: `Start` held high through DONE is accepted on the DONE-exit edge.
- `Result` shows intermediate values while `Busy`=1. It is valid only in the `Done` cycle and until the next accept.
- Outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then LSL A=0x0001 N=4: `Busy` high 4 cycles, then `Done` pulse; `Result`=0x0010, `CarryOut`=0.
- ASR A=0x8001 N=3: `Result`=0xF000, `CarryOut`=0. ROR A=0x1234 N=4: `Result`=0x4123, `CarryOut`=0.
- LSR A=0xFFFF N=15: `Done` in the cycle following the 15th edge after accept; `Result`=0x0001, `CarryOut`=1.
- N=0 with A=0xBEEF, any Op: `Busy` stays 0, `Done` in the next cycle, `Result`=0xBEEF, `CarryOut`=0.
- LSL A=0x0003 N=10, pulse `Start` with A=0xFFFF at cycle 3 (ignored), assert `RST` at cycle 5: `Busy`=0, `Done` never pulses, `Result`=0, `CarryOut`=0. Then a new request runs normally.
- Back-to-back: `Start` held high with LSL A=0x0001 N=1, then ROR A=0x0001 N=1 presented during the first `Done`. Second accept happens on the DONE-exit edge; second `Result`=0x8000, `CarryOut`=1.
